// File: rtl/mau_pkg.sv
// Shared types and decode helpers for the load/store unit (mem_access_unit).
package mau_pkg;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR, RESP} mau_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Byte-enable pattern for an access of this size, before shifting to its lane.
  function automatic logic [7:0] size_mask(logic [2:0] f3);
    unique case (f3[1:0])
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Low address bits that survive natural alignment for this size.
  function automatic logic [2:0] align_mask(logic [2:0] f3);
    unique case (f3[1:0])
      2'd0:    return 3'b111;
      2'd1:    return 3'b110;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic f3_illegal(logic we, logic [2:0] f3);
    return we ? f3[2] : (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/mau_if.sv
// Request/response and Memoria64 signals of mem_access_unit; slave = the unit, master = its environment.
interface mau_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] mem_raddr;
  logic [63:0] mem_rdata;
  logic [63:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic        mem_wr;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_raddr, mem_waddr, mem_wdata, mem_wr
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_raddr, mem_waddr, mem_wdata, mem_wr
  );
endinterface

// File: rtl/mau_lane_align.sv
// Combinational lane handling: load extract/extend and sub-doubleword store byte merge.
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [2:0]  i_off,
  input  logic [63:0] i_rdata,
  input  logic [63:0] i_wdata,
  output logic [63:0] o_load,
  output logic [63:0] o_merge
);

  logic [5:0]  w_sh;
  logic [63:0] w_lane;
  logic [63:0] w_wsh;
  logic [7:0]  w_bmask;

  assign w_sh    = {i_off, 3'b000};
  assign w_lane  = i_rdata >> w_sh;
  assign w_wsh   = i_wdata << w_sh;
  assign w_bmask = size_mask(i_funct3) << i_off;

  always_comb begin
    o_load = w_lane;
    case (i_funct3)
      F3_B:    o_load = {{56{w_lane[7]}}, w_lane[7:0]};
      F3_H:    o_load = {{48{w_lane[15]}}, w_lane[15:0]};
      F3_W:    o_load = {{32{w_lane[31]}}, w_lane[31:0]};
      F3_BU:   o_load = {56'd0, w_lane[7:0]};
      F3_HU:   o_load = {48'd0, w_lane[15:0]};
      F3_WU:   o_load = {32'd0, w_lane[31:0]};
      default: o_load = w_lane;
    endcase
  end

  always_comb begin
    o_merge = i_rdata;
    for (int i = 0; i < 8; i++) begin
      if (w_bmask[i]) o_merge[i*8 +: 8] = w_wsh[i*8 +: 8];
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage to Memoria64: one request at a time, RMW for sub-dword stores.
// Optional MAU_MISALIGN_TRAP_EN: misaligned accesses respond with an error instead of aligning down.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic CLK,
  input  logic RESET,
  mau_if.slave bus
);

  localparam logic [2:0] LatInit = 3'(MEM_LAT);

  mau_state_e  r_state;
  logic [2:0]  r_cnt;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [2:0]  r_off;
  logic [63:0] r_wdata;
  logic        r_ready;
  logic        r_resp_valid;
  logic [63:0] r_resp_rdata;
  logic        r_resp_err;
  logic [63:0] r_mem_raddr;
  logic [63:0] r_mem_waddr;
  logic [63:0] r_mem_wdata;
  logic        r_mem_wr;

  logic        w_err;
  logic [2:0]  w_off;
  logic [63:0] w_daddr;
  logic [63:0] w_load;
  logic [63:0] w_merge;

  assign w_off   = bus.req_addr[2:0] & align_mask(bus.req_funct3);
  assign w_daddr = {bus.req_addr[63:3], 3'b000};

`ifdef MAU_MISALIGN_TRAP_EN
  assign w_err = f3_illegal(bus.req_we, bus.req_funct3) |
                 (|(bus.req_addr[2:0] & ~align_mask(bus.req_funct3)));
`else
  assign w_err = f3_illegal(bus.req_we, bus.req_funct3);
`endif

  mau_lane_align u_lane_align (
    .i_funct3 (r_f3),
    .i_off    (r_off),
    .i_rdata  (bus.mem_rdata),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merge  (w_merge)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_f3         <= '0;
      r_off        <= '0;
      r_wdata      <= '0;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_mem_raddr  <= '0;
      r_mem_waddr  <= '0;
      r_mem_wdata  <= '0;
      r_mem_wr     <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_mem_wr     <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.req_valid && r_ready) begin
            r_we    <= bus.req_we;
            r_f3    <= bus.req_funct3;
            r_off   <= w_off;
            r_wdata <= bus.req_wdata;
            r_ready <= 1'b0;
            if (w_err) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else if (bus.req_we && bus.req_funct3 == F3_D) begin
              r_state     <= WR;
              r_mem_wr    <= 1'b1;
              r_mem_waddr <= w_daddr;
              r_mem_wdata <= bus.req_wdata;
            end else begin
              r_state     <= RD_WAIT;
              r_cnt       <= LatInit;
              r_mem_raddr <= w_daddr;
            end
          end
        end
        RD_WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            if (r_we) begin
              r_state     <= WR;
              r_mem_wr    <= 1'b1;
              r_mem_waddr <= r_mem_raddr;
              r_mem_wdata <= w_merge;
            end else begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b0;
              r_resp_rdata <= w_load;
            end
          end
        end
        WR: begin
          r_state      <= RESP;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= '0;
        end
        RESP: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = r_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
  assign bus.mem_raddr  = r_mem_raddr;
  assign bus.mem_waddr  = r_mem_waddr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.mem_wr     = r_mem_wr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit with a zero-wait Memoria64 model (MEM_LAT=1).
module tb_mem_access_unit;

  logic CLK;
  logic RESET;
  mau_if bus ();

  mem_access_unit #(.MEM_LAT(1)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memoria64 model: 8 doublewords, combinational read, write on mem_wr.
  logic [63:0] mem [0:7];
  assign bus.mem_rdata = mem[bus.mem_raddr[5:3]];

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < 8; i++) mem[i] <= 64'd0;
      mem[2] <= 64'h8877_6655_4433_2211;
    end else if (bus.mem_wr) begin
      mem[bus.mem_waddr[5:3]] <= bus.mem_wdata;
    end
  end

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
    int          nwr;
    int          wcyc;
    logic [63:0] waddr;
    logic [63:0] wdata;
  } exp_t;

  exp_t sb[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] rdata, input logic err, input int lat,
                              input int nwr, input int wcyc, input logic [63:0] waddr,
                              input logic [63:0] wdata);
    exp_t e;
    e.rdata = rdata; e.err = err; e.lat = lat; e.nwr = nwr; e.wcyc = wcyc;
    e.waddr = waddr; e.wdata = wdata;
    return e;
  endfunction

  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wdata, input exp_t e);
    int cyc, nwr, wcyc;
    logic got;
    logic [63:0] wa, wd;
    exp_t x;
    sb.push_back(e);
    @(negedge CLK);
    check({tag, " ready"}, 64'(bus.req_ready), 64'd1);
    bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = addr; bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    @(posedge CLK);
    #1 bus.req_valid = 1'b0;
    cyc = 0; nwr = 0; wcyc = 0; got = 1'b0; wa = '0; wd = '0;
    while (!got && cyc < 20) begin
      @(negedge CLK);
      cyc++;
      if (bus.mem_wr) begin nwr++; wcyc = cyc; wa = bus.mem_waddr; wd = bus.mem_wdata; end
      if (bus.resp_valid) got = 1'b1;
    end
    x = sb.pop_front();
    check({tag, " resp seen"}, 64'(got), 64'd1);
    check({tag, " latency"}, 64'(cyc), 64'(x.lat));
    check({tag, " rdata"}, bus.resp_rdata, x.rdata);
    check({tag, " err"}, 64'(bus.resp_err), 64'(x.err));
    @(negedge CLK);
    if (bus.mem_wr) nwr++;
    check({tag, " resp pulse"}, 64'(bus.resp_valid), 64'd0);
    check({tag, " write count"}, 64'(nwr), 64'(x.nwr));
    if (x.nwr > 0) begin
      check({tag, " write cycle"}, 64'(wcyc), 64'(x.wcyc));
      check({tag, " waddr"}, wa, x.waddr);
      check({tag, " wdata"}, wd, x.wdata);
    end
  endtask

  initial begin
    logic [63:0] raddr_before;
    int nwr;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst ready", 64'(bus.req_ready), 64'd1);
    check("rst resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst resp_err", 64'(bus.resp_err), 64'd0);
    check("rst resp_rdata", bus.resp_rdata, 64'd0);
    check("rst mem_wr", 64'(bus.mem_wr), 64'd0);
    check("rst raddr", bus.mem_raddr, 64'd0);
    check("rst waddr", bus.mem_waddr, 64'd0);
    check("rst wdata", bus.mem_wdata, 64'd0);
    RESET = 1'b1;

    do_req("LB 0x17", 1'b0, 3'b000, 64'h17, 64'd0, mk(64'hFFFF_FFFF_FFFF_FF88, 0, 2, 0, 0, 0, 0));
    do_req("LWU 0x14", 1'b0, 3'b110, 64'h14, 64'd0, mk(64'h0000_0000_8877_6655, 0, 2, 0, 0, 0, 0));
    do_req("LHU 0x10", 1'b0, 3'b101, 64'h10, 64'd0, mk(64'h2211, 0, 2, 0, 0, 0, 0));
    do_req("LH 0x16", 1'b0, 3'b001, 64'h16, 64'd0, mk(64'hFFFF_FFFF_FFFF_8877, 0, 2, 0, 0, 0, 0));
    do_req("LD 0x10", 1'b0, 3'b011, 64'h10, 64'd0, mk(64'h8877_6655_4433_2211, 0, 2, 0, 0, 0, 0));
`ifdef MAU_MISALIGN_TRAP_EN
    do_req("LW 0x12", 1'b0, 3'b010, 64'h12, 64'd0, mk(64'd0, 1, 1, 0, 0, 0, 0));
`else
    do_req("LW 0x12", 1'b0, 3'b010, 64'h12, 64'd0, mk(64'h4433_2211, 0, 2, 0, 0, 0, 0));
`endif
    do_req("load f3=7", 1'b0, 3'b111, 64'h10, 64'd0, mk(64'd0, 1, 1, 0, 0, 0, 0));
    do_req("store f3=4", 1'b1, 3'b100, 64'h10, 64'h55, mk(64'd0, 1, 1, 0, 0, 0, 0));
    do_req("SB 0x11", 1'b1, 3'b000, 64'h11, 64'hFFFF_FFFF_FFFF_CDAB,
           mk(64'd0, 0, 3, 1, 2, 64'h10, 64'h8877_6655_4433_AB11));
    raddr_before = bus.mem_raddr;
    do_req("SD 0x18", 1'b1, 3'b011, 64'h18, 64'hDEAD_BEEF,
           mk(64'd0, 0, 2, 1, 1, 64'h18, 64'h0000_0000_DEAD_BEEF));
    check("SD no read", bus.mem_raddr, raddr_before);
    do_req("LD 0x18", 1'b0, 3'b011, 64'h18, 64'd0, mk(64'h0000_0000_DEAD_BEEF, 0, 2, 0, 0, 0, 0));
    do_req("SW 0x14", 1'b1, 3'b010, 64'h14, 64'hAAAA_AAAA_1234_5678,
           mk(64'd0, 0, 3, 1, 2, 64'h10, 64'h1234_5678_4433_AB11));
    do_req("LB 0x13", 1'b0, 3'b000, 64'h13, 64'd0, mk(64'h44, 0, 2, 0, 0, 0, 0));

    // Abort a store in RD_WAIT by asserting reset.
    @(negedge CLK);
    bus.req_we = 1'b1; bus.req_funct3 = 3'b000; bus.req_addr = 64'h11;
    bus.req_wdata = 64'h77; bus.req_valid = 1'b1;
    @(posedge CLK);
    #1 bus.req_valid = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("abort ready", 64'(bus.req_ready), 64'd1);
    check("abort mem_wr", 64'(bus.mem_wr), 64'd0);
    nwr = 0;
    @(negedge CLK);
    RESET = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      if (bus.mem_wr || bus.resp_valid) nwr++;
    end
    check("abort silent", 64'(nwr), 64'd0);
    do_req("LB 0x10 after abort", 1'b0, 3'b000, 64'h10, 64'd0, mk(64'h11, 0, 2, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
